// File: rtl/can_receiver.sv
// CAN frame receiver: decodes de-stuffed bus bits into ID, control and data fields.
// Extended (29-bit ID) frame decoding is enabled by defining CAN_RX_EXT_ID_EN.
module can_receiver (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_bit_curr,
  input  logic             sample_point,
  input  logic             remove_stuff_bit,
  output logic [7:0][7:0]  rx_data_array,
  output logic             rx_done_flag,
  output logic [10:0]      rx_id_std,
  output logic [17:0]      rx_id_ext,
  output logic             rx_ide,
  output logic [3:0]       rx_dlc,
  output logic             rx_remote_req
);

  localparam int unsigned ID_STD_W  = 11;
  localparam int unsigned DLC_W     = 4;
  localparam int unsigned CRC_W     = 15;
  localparam int unsigned EOF_W     = 7;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned MAX_BYTES = 8;
`ifdef CAN_RX_EXT_ID_EN
  localparam int unsigned ID_EXT_W  = 18;
`endif

  typedef enum logic [3:0] {
    IDLE, ID_STD, SRR_RTR, IDE, ID_EXT, RTR_EXT, R1, R0,
    DLC, DATA, CRC, CRC_DELIM, ACK, ACK_DELIM, EOF
  } state_t;

  state_t             state;
  logic               sp_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DLC_W-1:0]   byte_idx;
  logic [DLC_W-1:0]   byte_num;
  logic               bit_evt;
  logic [DLC_W-1:0]   dlc_next;

  // One event per rising edge of the sample strobe; stuff bits are dropped.
  assign bit_evt  = sample_point & ~sp_q & ~remove_stuff_bit;
  assign dlc_next = {rx_dlc[DLC_W-2:0], rx_bit_curr};

`ifndef CAN_RX_EXT_ID_EN
  assign rx_id_ext = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sp_q          <= 1'b0;
      bit_cnt       <= '0;
      byte_idx      <= '0;
      byte_num      <= '0;
      rx_data_array <= '0;
      rx_done_flag  <= 1'b0;
      rx_id_std     <= '0;
      rx_ide        <= 1'b0;
      rx_dlc        <= '0;
      rx_remote_req <= 1'b0;
`ifdef CAN_RX_EXT_ID_EN
      rx_id_ext     <= '0;
`endif
    end else begin
      sp_q <= sample_point;
      if (bit_evt) begin
        case (state)
          IDLE: if (!rx_bit_curr) begin
            state         <= ID_STD;
            rx_done_flag  <= 1'b0;
            rx_data_array <= '0;
            bit_cnt       <= '0;
            byte_idx      <= '0;
            byte_num      <= '0;
`ifdef CAN_RX_EXT_ID_EN
            rx_id_ext     <= '0;
`endif
          end
          ID_STD: begin
            rx_id_std <= {rx_id_std[ID_STD_W-2:0], rx_bit_curr};
            if (bit_cnt == CNT_W'(ID_STD_W - 1)) begin
              bit_cnt <= '0;
              state   <= SRR_RTR;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          SRR_RTR: begin
            rx_remote_req <= rx_bit_curr;
            state         <= IDE;
          end
          IDE: begin
            rx_ide <= rx_bit_curr;
`ifdef CAN_RX_EXT_ID_EN
            state  <= rx_bit_curr ? ID_EXT : R0;
`else
            // Extended frames are not supported in this build: abandon the frame.
            state  <= rx_bit_curr ? IDLE : R0;
`endif
          end
`ifdef CAN_RX_EXT_ID_EN
          ID_EXT: begin
            rx_id_ext <= {rx_id_ext[ID_EXT_W-2:0], rx_bit_curr};
            if (bit_cnt == CNT_W'(ID_EXT_W - 1)) begin
              bit_cnt <= '0;
              state   <= RTR_EXT;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          RTR_EXT: begin
            rx_remote_req <= rx_bit_curr;
            state         <= R1;
          end
          R1: state <= R0;
`endif
          R0: state <= DLC;
          DLC: begin
            rx_dlc <= dlc_next;
            if (bit_cnt == CNT_W'(DLC_W - 1)) begin
              bit_cnt  <= '0;
              byte_idx <= '0;
              byte_num <= (dlc_next > DLC_W'(MAX_BYTES)) ? DLC_W'(MAX_BYTES) : dlc_next;
              state    <= (dlc_next == '0 || rx_remote_req) ? CRC : DATA;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          DATA: begin
            rx_data_array[byte_idx[2:0]] <= {rx_data_array[byte_idx[2:0]][6:0], rx_bit_curr};
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt  <= '0;
              byte_idx <= byte_idx + DLC_W'(1);
              if (byte_idx + DLC_W'(1) == byte_num) state <= CRC;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          CRC: begin
            if (bit_cnt == CNT_W'(CRC_W - 1)) begin
              bit_cnt <= '0;
              state   <= CRC_DELIM;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          CRC_DELIM: state <= rx_bit_curr ? ACK : IDLE;
          ACK:       state <= ACK_DELIM;
          ACK_DELIM: state <= rx_bit_curr ? EOF : IDLE;
          EOF: begin
            // Any dominant EOF bit is a form error: drop back without flagging done.
            if (!rx_bit_curr) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else if (bit_cnt == CNT_W'(EOF_W - 1)) begin
              bit_cnt      <= '0;
              rx_done_flag <= 1'b1;
              state        <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_receiver.sv
// Self-checking bench for can_receiver: frame-level reference model, per-cycle done check,
// directed frames plus randomized frames with random stuff bits and strobe widths.
module tb_can_receiver;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx_bit_curr = 1'b1;
  logic            sample_point = 1'b0;
  logic            remove_stuff_bit = 1'b0;
  logic [7:0][7:0] rx_data_array;
  logic            rx_done_flag;
  logic [10:0]     rx_id_std;
  logic [17:0]     rx_id_ext;
  logic            rx_ide;
  logic [3:0]      rx_dlc;
  logic            rx_remote_req;

  can_receiver dut (
    .clk(clk), .rst_n(rst_n), .rx_bit_curr(rx_bit_curr), .sample_point(sample_point),
    .remove_stuff_bit(remove_stuff_bit), .rx_data_array(rx_data_array),
    .rx_done_flag(rx_done_flag), .rx_id_std(rx_id_std), .rx_id_ext(rx_id_ext),
    .rx_ide(rx_ide), .rx_dlc(rx_dlc), .rx_remote_req(rx_remote_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0]     id_std;
    logic [17:0]     id_ext;
    logic            ide;
    logic            rtr;
    logic [3:0]      dlc;
    logic [7:0][7:0] data;
  } frame_t;

  typedef struct packed {
    logic            done;
    logic [10:0]     id_std;
    logic [17:0]     id_ext;
    logic            ide;
    logic [3:0]      dlc;
    logic            rtr;
    logic [7:0][7:0] data;
  } exp_t;

  int    n_checks = 0;
  int    n_fail = 0;
  exp_t  m = '0;
  logic  exp_done = 1'b0;
  logic  cmp_en = 1'b1;
  logic  rnd_timing = 1'b0;
  logic  q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Done flag must match the frame-level expectation on every cycle.
  always @(negedge clk) if (cmp_en) chk("done_cycle", {63'd0, rx_done_flag}, {63'd0, exp_done});

  task automatic check_all(input string tag);
    chk({tag, "_done"}, {63'd0, rx_done_flag}, {63'd0, m.done});
    chk({tag, "_id_std"}, {53'd0, rx_id_std}, {53'd0, m.id_std});
    chk({tag, "_id_ext"}, {46'd0, rx_id_ext}, {46'd0, m.id_ext});
    chk({tag, "_ide"}, {63'd0, rx_ide}, {63'd0, m.ide});
    chk({tag, "_dlc"}, {60'd0, rx_dlc}, {60'd0, m.dlc});
    chk({tag, "_rtr"}, {63'd0, rx_remote_req}, {63'd0, m.rtr});
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_data%0d", tag, i), {56'd0, rx_data_array[i]}, {56'd0, m.data[i]});
  endtask

  function automatic int nbytes(input frame_t f);
    if (f.rtr) return 0;
    return (f.dlc > 4'd8) ? 8 : int'(f.dlc);
  endfunction

  // Frame-level reference: kind 0 = good frame, 1 = form error after data, 2 = IDE rejected.
  function automatic exp_t model(input exp_t prev, input frame_t f, input int kind);
    exp_t e;
    e = prev;
    e.done   = (kind == 0);
    e.data   = '0;
    e.id_ext = '0;
    e.id_std = f.id_std;
    e.ide    = f.ide;
    if (kind == 2) begin
      e.rtr = 1'b1;
      return e;
    end
    e.rtr = f.rtr;
    e.dlc = f.dlc;
    if (f.ide) e.id_ext = f.id_ext;
    for (int i = 0; i < nbytes(f); i++) e.data[i] = f.data[i];
    return e;
  endfunction

  task automatic build_frame(input frame_t f, input logic [14:0] crc, input logic ack);
    q.delete();
    q.push_back(1'b0);
    for (int i = 10; i >= 0; i--) q.push_back(f.id_std[i]);
    q.push_back(f.ide ? 1'b1 : f.rtr);
    q.push_back(f.ide);
    if (f.ide) begin
      for (int i = 17; i >= 0; i--) q.push_back(f.id_ext[i]);
      q.push_back(f.rtr);
      q.push_back(1'($urandom_range(1)));
    end
    q.push_back(1'($urandom_range(1)));
    for (int i = 3; i >= 0; i--) q.push_back(f.dlc[i]);
    for (int b = 0; b < nbytes(f); b++)
      for (int i = 7; i >= 0; i--) q.push_back(f.data[b][i]);
    for (int i = 14; i >= 0; i--) q.push_back(crc[i]);
    q.push_back(1'b1);
    q.push_back(ack);
    q.push_back(1'b1);
    for (int i = 0; i < 7; i++) q.push_back(1'b1);
  endtask

  // ev: 1 = SOF (done expected low afterwards), 2 = last EOF bit of a good frame.
  task automatic send_bit(input logic b, input logic stuff, input int ev);
    int hi, lo;
    hi = rnd_timing ? int'($urandom_range(1, 3)) : 2;
    lo = rnd_timing ? int'($urandom_range(1, 3)) : 2;
    @(negedge clk);
    rx_bit_curr = b;
    remove_stuff_bit = stuff;
    sample_point = 1'b1;
    @(posedge clk);
    #1;
    if (ev == 1) exp_done = 1'b0;
    if (ev == 2) exp_done = 1'b1;
    repeat (hi - 1) @(posedge clk);
    @(negedge clk);
    sample_point = 1'b0;
    remove_stuff_bit = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int upto, input int stuff_at, input logic rnd_stuff, input logic ok);
    for (int i = 0; i <= upto; i++) begin
      if (i == stuff_at || (rnd_stuff && $urandom_range(7) == 0))
        send_bit(1'($urandom_range(1)), 1'b1, 0);
      send_bit(q[i], 1'b0, (i == 0) ? 1 : ((ok && i == q.size() - 1) ? 2 : 0));
    end
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0, 0);
  endtask

  task automatic run_frame(input frame_t f, input int kind, input int stuff_at, input logic rnd_stuff,
                           input string tag);
    int upto, r;
    build_frame(f, 15'($urandom), 1'($urandom_range(1)));
    upto = q.size() - 1;
    if (kind == 2) upto = 13;
    if (kind == 1) begin
      r = int'($urandom_range(8));
      upto = (r == 0) ? q.size() - 10 : (r == 1) ? q.size() - 8 : q.size() - 9 + r;
      q[upto] = 1'b0;
    end
    send_frame(upto, stuff_at, rnd_stuff, kind == 0);
    send_idle(3);
    m = model(m, f, kind);
    check_all(tag);
  endtask

  initial begin
    frame_t f;
    int kind;
    #12;
    check_all("reset");
    chk("reset_id_lit", {53'd0, rx_id_std}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Standard data frame, fixed 2-cycle strobe; CRC all ones, ACK dominant.
    f = '0; f.id_std = 11'h7FF; f.dlc = 4'd2; f.data[0] = 8'hAB; f.data[1] = 8'hCD;
    build_frame(f, 15'h7FFF, 1'b0);
    send_frame(q.size() - 1, -1, 1'b0, 1'b1);
    send_idle(3);
    m = model(m, f, 0);
    check_all("std");
    chk("std_id_lit", {53'd0, rx_id_std}, 64'h7FF);
    chk("std_dlc_lit", {60'd0, rx_dlc}, 64'd2);
    chk("std_d0_lit", {56'd0, rx_data_array[0]}, 64'hAB);
    chk("std_d1_lit", {56'd0, rx_data_array[1]}, 64'hCD);
    chk("std_done_lit", {63'd0, rx_done_flag}, 64'd1);

    // Same frame with a stuff bit after 5 ID bits.
    run_frame(f, 0, 6, 1'b0, "stuff");
    chk("stuff_d1_lit", {56'd0, rx_data_array[1]}, 64'hCD);

    // Remote frame: no data bits even though DLC = 4.
    f = '0; f.id_std = 11'h100; f.rtr = 1'b1; f.dlc = 4'd4; f.data = 64'hFFFF_FFFF_FFFF_FFFF;
    run_frame(f, 0, -1, 1'b0, "remote");
    chk("remote_rtr_lit", {63'd0, rx_remote_req}, 64'd1);
    chk("remote_data_lit", rx_data_array, 64'd0);

    // DLC 15 clamps to 8 bytes.
    f = '0; f.id_std = 11'h2A5; f.dlc = 4'hF;
    for (int i = 0; i < 8; i++) f.data[i] = 8'(i + 1);
    run_frame(f, 0, -1, 1'b0, "dlc15");
    chk("dlc15_dlc_lit", {60'd0, rx_dlc}, 64'd15);
    chk("dlc15_d7_lit", {56'd0, rx_data_array[7]}, 64'h08);

    // Dominant EOF bit: frame fields decoded but done stays low.
    build_frame(f, 15'h1234, 1'b0);
    q[q.size() - 3] = 1'b0;
    send_frame(q.size() - 3, -1, 1'b0, 1'b0);
    send_idle(3);
    m = model(m, f, 1);
    check_all("eof_err");
    chk("eof_err_done_lit", {63'd0, rx_done_flag}, 64'd0);

`ifdef CAN_RX_EXT_ID_EN
    f = '0; f.id_std = 11'h123; f.id_ext = 18'h2AAAA; f.ide = 1'b1; f.dlc = 4'd1; f.data[0] = 8'h5A;
    run_frame(f, 0, -1, 1'b0, "ext");
    chk("ext_id_ext_lit", {46'd0, rx_id_ext}, 64'h2AAAA);
    chk("ext_d0_lit", {56'd0, rx_data_array[0]}, 64'h5A);
`else
    f = '0; f.id_std = 11'h123; f.id_ext = 18'h2AAAA; f.ide = 1'b1; f.dlc = 4'd1; f.data[0] = 8'h5A;
    run_frame(f, 2, -1, 1'b0, "ide_rej");
    chk("ide_rej_ext_lit", {46'd0, rx_id_ext}, 64'd0);
`endif

    // Reset in the middle of the data field, then a clean frame.
    f = '0; f.id_std = 11'h555; f.dlc = 4'd8;
    for (int i = 0; i < 8; i++) f.data[i] = 8'($urandom);
    build_frame(f, 15'h0, 1'b0);
    send_frame(30, -1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_done = 1'b0;
    m = '0;
    #1;
    check_all("midrst");
    chk("midrst_d0_lit", {56'd0, rx_data_array[0]}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(f, 0, -1, 1'b0, "postrst");

    // Randomized frames, strobe widths and stuff bits.
    rnd_timing = 1'b1;
    for (int n = 0; n < 24; n++) begin
      f.id_std = 11'($urandom);
      f.id_ext = 18'($urandom);
      f.rtr    = ($urandom_range(3) == 0);
      f.dlc    = 4'($urandom);
      f.data   = {$urandom, $urandom};
`ifdef CAN_RX_EXT_ID_EN
      f.ide = 1'($urandom_range(1));
      kind  = ($urandom_range(5) == 0) ? 1 : 0;
`else
      f.ide = ($urandom_range(4) == 0);
      kind  = f.ide ? 2 : (($urandom_range(5) == 0) ? 1 : 0);
`endif
      run_frame(f, kind, -1, 1'b1, $sformatf("rnd%0d", n));
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/can_receiver.md
CAN_RECEIVER -- requirements
Module: can_receiver

Interface
REQ-001 SHALL have no parameters; data array fixed at 8 bytes x 8 bits.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rx_bit_curr  input  1  de-stuffing-stage bus bit; 0 = dominant, 1 = recessive.
REQ-005 sample_point  input  1  bit-timing sample strobe.
REQ-006 remove_stuff_bit  input  1  high = current sampled bit is a stuff bit, to be discarded.
REQ-007 rx_data_array  output  8x[7:0]  received data bytes, index 0 = first byte on bus.
REQ-008 rx_done_flag  output  1  frame received completely and correctly framed.
REQ-009 rx_id_std  output  11  base identifier.
REQ-010 rx_id_ext  output  18  extended identifier.
REQ-011 rx_ide  output  1  received IDE bit.
REQ-012 rx_dlc  output  4  received data length code, raw.
REQ-013 rx_remote_req  output  1  received RTR bit.

Function
REQ-014 Bit event SHALL occur on a clk edge where sample_point = 1 and its registered copy = 0 (rising-edge detect); one bit per sample_point pulse regardless of pulse width.
REQ-015 Bit events with remove_stuff_bit = 1 SHALL be ignored (no state or field change).
REQ-016 States: IDLE, ID_STD, SRR_RTR, IDE, ID_EXT, RTR_EXT, R1, R0, DLC, DATA, CRC, CRC_DELIM, ACK, ACK_DELIM, EOF.
REQ-017 IDLE: dominant bit = SOF -> ID_STD; clear rx_done_flag, rx_data_array, rx_id_ext, bit counters; recessive stays IDLE.
REQ-018 ID_STD: 11 bits MSB first into rx_id_std -> SRR_RTR; that bit captured into rx_remote_req -> IDE.
REQ-019 IDE = 0: rx_ide = 0 -> R0 -> DLC. IDE = 1: rx_ide = 1 -> ID_EXT (18 bits MSB first) -> RTR_EXT (overwrites rx_remote_req) -> R1 -> R0 -> DLC.
REQ-020 DLC: 4 bits MSB first into rx_dlc; byte count = min(DLC, 8); count 0 or rx_remote_req = 1 -> CRC, else DATA.
REQ-021 DATA: bytes MSB first into rx_data_array[0..count-1]; after last bit -> CRC; unreceived bytes remain 0.
REQ-022 CRC: 15 bits consumed, not checked, not output -> CRC_DELIM.
REQ-023 CRC_DELIM, ACK_DELIM and each of 7 EOF bits SHALL be recessive; dominant -> IDLE, rx_done_flag stays 0 (form error).
REQ-024 ACK slot: any value accepted -> ACK_DELIM -> EOF.
REQ-025 On the clock after 7th EOF bit: rx_done_flag = 1, -> IDLE; flag SHALL stay high until next SOF or reset.
REQ-026 Output fields SHALL hold last values between frames except as cleared per REQ-017.
REQ-027 Reserved bits r0/r1 SHALL be accepted with any value.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, all counters 0, all outputs 0 (all 8 data bytes 0x00).
REQ-029 Reset mid-frame SHALL abandon the frame; first dominant bit after release is treated as SOF.

Configuration
REQ-030 Macro CAN_RX_EXT_ID_EN defined: extended frames decoded per REQ-019.
REQ-031 Macro undefined: IDE = 1 SHALL send FSM to IDLE without rx_done_flag; rx_id_ext tied 0; ID_EXT/RTR_EXT/R1 logic absent.

Verification
REQ-032 Std frame SOF, ID 0x7FF, RTR 0, IDE 0, r0 0, DLC 0010, data 0xAB 0xCD, CRC all 1s, delim 1, ACK 0, ACK delim 1, 7+3 recessive, sample_point 20 ns half-period, clk 10 ns -> rx_done_flag = 1, rx_id_std = 0x7FF, rx_dlc = 2, rx_data_array[0] = 0xAB, [1] = 0xCD, rx_ide = 0, rx_remote_req = 0.
REQ-033 Extended frame (macro defined) base 0x123, ext 0x2AAAA, DLC 1, data 0x5A -> rx_ide = 1, rx_id_std = 0x123, rx_id_ext = 0x2AAAA, rx_data_array[0] = 0x5A, done = 1.
REQ-034 Remote frame ID 0x100, RTR 1, DLC 4 -> no data bits expected, done = 1, rx_remote_req = 1, data array all 0.
REQ-035 Same as REQ-032 with an extra bit flagged remove_stuff_bit = 1 inserted after 5 ID bits -> identical results.
REQ-036 DLC 1111 with 8 data bytes 0x01..0x08 -> rx_dlc = 15, bytes 0x01..0x08, done = 1; dominant EOF bit variant -> done stays 0, FSM IDLE.
REQ-037 rst_n pulsed low during DATA -> all outputs 0; next full frame decodes correctly.
